regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Shares the 16 x 64-bit two-read/one-write register file between two requesters (port 0, port 1) using round-robin arbitration.
- Sequences a post-reset clear pass that writes zero to every register.
- Drives the regfile's I1/si1/so1/so2/RD/WR/EN and returns read data per requester with fixed latency.
- Sits between the execute-stage requesters and the regfile instance.

Parameters:
DW, 64, data width (regfile word width)
AW, 4, register address width
NREG, 16, number of registers cleared by init sequence (2**AW)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle when valid&ready
req0_we  in  1  1 = write op, 0 = read op
req0_waddr  in  AW  write address
req0_wdata  in  DW  write data
req0_raddr1  in  AW  read address, operand 1
req0_raddr2  in  AW  read address, operand 2
rsp0_valid  out  1  port 0 read response valid (one-cycle pulse)
rsp0_rdata1  out  DW  operand 1 read data
rsp0_rdata2  out  DW  operand 2 read data
req1_*/rsp1_*  same set as port 0, for port 1
rf_I1  out  DW  regfile write data
rf_si1  out  AW  regfile write address
rf_so1  out  AW  regfile read address 1
rf_so2  out  AW  regfile read address 2
rf_RD  out  1  regfile read strobe
rf_WR  out  1  regfile write strobe
rf_EN  out  1  regfile enable
rf_O1  in  DW  regfile read data 1 (combinational on so1 while RD=1)
rf_O2  in  DW  regfile read data 2 (combinational on so2 while RD=1)
init_done  out  1  clear pass complete

Behaviour:
- Regfile contract (decided): write commits on the rising clk edge while WR&EN; read data is combinational while RD&EN.
- Reset: all outputs 0; state <= INIT; clear counter <= 0; RR pointer <= 0; pending response pipeline flushed.
- INIT state:
  - Each cycle drive rf_WR=1, rf_EN=1, rf_I1=0, rf_si1=counter; counter increments.
  - After counter = NREG-1 (NREG cycles), go to RUN; init_done=1 from the next cycle and stays 1 until rst.
  - reqN_ready=0 throughout INIT.
- RUN state, arbitration (combinational):
  - One valid requester: it is granted.
  - Both valid: port = RR pointer is granted.
  - reqN_ready = init_done & grant==N.
  - Pointer moves to the other port after every accepted request; it does not move when idle.
  - Throughput: one accept per cycle.
- Issue (registered): a request accepted in cycle T drives the regfile in T+1.
  - Write: rf_WR=1, rf_EN=1, rf_si1=waddr, rf_I1=wdata.
  - Read: rf_RD=1, rf_EN=1, rf_so1/rf_so2=raddr1/raddr2.
  - No accept in T: all rf strobes 0 in T+1, addresses and data hold their last value.
- Response:
  - For a read, rf_O1/rf_O2 are captured at the end of T+1.
  - rspN_valid=1 for exactly cycle T+2 with the captured data; port ID is carried along the pipeline.
  - Writes produce no response.
  - No response backpressure: requesters always accept rsp.
- Hazards:
  - Write accepted T, read of the same address accepted T+1 returns the new value (write commits at the end of T+1; read is sampled at the end of T+2).
  - A read and a write never issue in the same cycle because there is one op per cycle.
- rst mid-operation: in-flight responses are dropped (rspN_valid stays 0), state returns to INIT, and the clear pass restarts from si1=0.
- A request is only consumed on valid&ready. A requester holds its fields stable while valid&!ready.

Optional Feature:
- Macro: REGFILE_ARB_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired zero. Writes to address 0 are accepted but rf_WR stays 0.
  - Any read operand with address 0 returns 0 in rsp data regardless of rf_O1/rf_O2.
  - The INIT pass still walks all NREG addresses.
- Undefined: register 0 behaves like every other register.

Test Plan:
- Reset (rst=1 for 1 cycle) -> next 16 cycles show rf_WR=1, rf_I1=0, rf_si1=0..15; init_done=1 in cycle 17; req0_ready=req1_ready=0 during INIT.
- req0 writes r3=64'h000F_0000_000F_0000, then req0 reads raddr1=3, raddr2=1 -> rsp0_valid exactly 2 cycles after read accept, rdata1=64'h000F_0000_000F_0000, rdata2=0; rsp1_valid stays 0.
- req0_valid and req1_valid held high 4 cycles after init -> grants 0,1,0,1; each port sees ready every other cycle.
- req1 writes r5=64'hF000_0000_000F_0000, then reads r5 on the next cycle -> rsp1_rdata1=64'hF000_0000_000F_0000.
- rst asserted the cycle after a read accept -> no rsp pulse; rf_si1 restarts at 0 with rf_WR=1; a value written earlier reads back 0 after init.
- REGFILE_ARB_R0_ZERO_EN defined: write r0=all ones -> rf_WR=0 in the issue cycle; read raddr1=0 -> rdata1=0.

Source files
------------

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin two-port front end and post-reset clear sequencer for the 16x64 regfile
// Optional macro REGFILE_ARB_R0_ZERO_EN: register 0 reads as zero and ignores writes.
module regfile_arbiter #(
    parameter int DW   = 64,
    parameter int AW   = 4,
    parameter int NREG = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_waddr,
    input  logic [DW-1:0] req0_wdata,
    input  logic [AW-1:0] req0_raddr1,
    input  logic [AW-1:0] req0_raddr2,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata1,
    output logic [DW-1:0] rsp0_rdata2,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_waddr,
    input  logic [DW-1:0] req1_wdata,
    input  logic [AW-1:0] req1_raddr1,
    input  logic [AW-1:0] req1_raddr2,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata1,
    output logic [DW-1:0] rsp1_rdata2,
    output logic [DW-1:0] rf_I1,
    output logic [AW-1:0] rf_si1,
    output logic [AW-1:0] rf_so1,
    output logic [AW-1:0] rf_so2,
    output logic          rf_RD,
    output logic          rf_WR,
    output logic          rf_EN,
    input  logic [DW-1:0] rf_O1,
    input  logic [DW-1:0] rf_O2,
    output logic          init_done
);

`ifdef REGFILE_ARB_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          init_done_q;
    logic          rr_q;
    logic          iss_wr_q, iss_rd_q, iss_port_q;
    logic [AW-1:0] si1_q, so1_q, so2_q;
    logic [DW-1:0] i1_q;
    logic          rsp_v_q, rsp_port_q;
    logic [DW-1:0] rsp_d1_q, rsp_d2_q;

    logic          gnt, accept, in_init;
    logic          sel_we;
    logic [AW-1:0] sel_waddr, sel_r1, sel_r2;
    logic [DW-1:0] sel_wdata;
    logic          wr_commit;

    // Round-robin pointer only breaks ties; a lone requester always wins.
    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid)
            gnt = rr_q;
        else if (req1_valid)
            gnt = 1'b1;
        sel_we    = gnt ? req1_we     : req0_we;
        sel_waddr = gnt ? req1_waddr  : req0_waddr;
        sel_wdata = gnt ? req1_wdata  : req0_wdata;
        sel_r1    = gnt ? req1_raddr1 : req0_raddr1;
        sel_r2    = gnt ? req1_raddr2 : req0_raddr2;
    end

    assign accept     = init_done_q & (req0_valid | req1_valid);
    assign req0_ready = init_done_q & ~gnt;
    assign req1_ready = init_done_q & gnt;
    assign wr_commit  = accept & sel_we & ~(R0_ZERO & (sel_waddr == '0));
    assign in_init    = (state_q == S_INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rr_q        <= 1'b0;
            iss_wr_q    <= 1'b0;
            iss_rd_q    <= 1'b0;
            iss_port_q  <= 1'b0;
            si1_q       <= '0;
            so1_q       <= '0;
            so2_q       <= '0;
            i1_q        <= '0;
            rsp_v_q     <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_d1_q    <= '0;
            rsp_d2_q    <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == LAST) begin
                        state_q     <= S_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: state_q <= S_RUN;
            endcase

            if (accept) begin
                rr_q       <= ~gnt;
                iss_port_q <= gnt;
            end
            iss_wr_q <= wr_commit;
            iss_rd_q <= accept & ~sel_we;
            if (accept && sel_we) begin
                si1_q <= sel_waddr;
                i1_q  <= sel_wdata;
            end
            if (accept && !sel_we) begin
                so1_q <= sel_r1;
                so2_q <= sel_r2;
            end

            // Read data is valid combinationally during the issue cycle; latch it at its end.
            rsp_v_q <= iss_rd_q;
            if (iss_rd_q) begin
                rsp_port_q <= iss_port_q;
                rsp_d1_q   <= (R0_ZERO && so1_q == '0) ? '0 : rf_O1;
                rsp_d2_q   <= (R0_ZERO && so2_q == '0) ? '0 : rf_O2;
            end
        end
    end

    assign rf_WR  = in_init | iss_wr_q;
    assign rf_RD  = iss_rd_q;
    assign rf_EN  = in_init | iss_wr_q | iss_rd_q;
    assign rf_I1  = in_init ? '0 : i1_q;
    assign rf_si1 = in_init ? cnt_q : si1_q;
    assign rf_so1 = so1_q;
    assign rf_so2 = so2_q;

    assign init_done   = init_done_q;
    assign rsp0_valid  = rsp_v_q & ~rsp_port_q;
    assign rsp1_valid  = rsp_v_q & rsp_port_q;
    assign rsp0_rdata1 = rsp_d1_q;
    assign rsp0_rdata2 = rsp_d2_q;
    assign rsp1_rdata1 = rsp_d1_q;
    assign rsp1_rdata2 = rsp_d2_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - scoreboard bench for regfile_arbiter with a behavioural regfile
module tb_regfile_arbiter;
    localparam int DW = 64;
    localparam int AW = 4;
    localparam int NREG = 16;

`ifdef REGFILE_ARB_R0_ZERO_EN
    localparam bit R0 = 1'b1;
`else
    localparam bit R0 = 1'b0;
`endif

    typedef struct {
        int            port;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    v = '0;
    logic [1:0]    we = '0;
    logic [AW-1:0] wa [2];
    logic [AW-1:0] r1 [2];
    logic [AW-1:0] r2 [2];
    logic [DW-1:0] wd [2];

    logic req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata1, rsp0_rdata2, rsp1_rdata1, rsp1_rdata2;
    logic [DW-1:0] rf_I1, rf_O1, rf_O2;
    logic [AW-1:0] rf_si1, rf_so1, rf_so2;
    logic rf_RD, rf_WR, rf_EN, init_done;

    regfile_arbiter #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_ready(req0_ready), .req0_we(we[0]), .req0_waddr(wa[0]),
        .req0_wdata(wd[0]), .req0_raddr1(r1[0]), .req0_raddr2(r2[0]),
        .rsp0_valid(rsp0_valid), .rsp0_rdata1(rsp0_rdata1), .rsp0_rdata2(rsp0_rdata2),
        .req1_valid(v[1]), .req1_ready(req1_ready), .req1_we(we[1]), .req1_waddr(wa[1]),
        .req1_wdata(wd[1]), .req1_raddr1(r1[1]), .req1_raddr2(r2[1]),
        .rsp1_valid(rsp1_valid), .rsp1_rdata1(rsp1_rdata1), .rsp1_rdata2(rsp1_rdata2),
        .rf_I1(rf_I1), .rf_si1(rf_si1), .rf_so1(rf_so1), .rf_so2(rf_so2),
        .rf_RD(rf_RD), .rf_WR(rf_WR), .rf_EN(rf_EN), .rf_O1(rf_O1), .rf_O2(rf_O2),
        .init_done(init_done)
    );

    // Behavioural regfile: write on clock edge, combinational read while enabled.
    logic [DW-1:0] rf_mem [NREG];
    always @(posedge clk) if (rf_WR && rf_EN) rf_mem[rf_si1] <= rf_I1;
    assign rf_O1 = (rf_RD && rf_EN) ? rf_mem[rf_so1] : 64'hDEAD_BEEF_DEAD_BEEF;
    assign rf_O2 = (rf_RD && rf_EN) ? rf_mem[rf_so2] : 64'hBAD0_BAD0_BAD0_BAD0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mmem [NREG];
    exp_t q[$];
    int rr_m = 0;
    int last_grant = -1;
    bit prev_acc = 0, prev_we = 0;
    logic [AW-1:0] prev_wa, prev_r1, prev_r2;
    logic [DW-1:0] prev_wd;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return (R0 && a == '0) ? '0 : mmem[a];
    endfunction

    always @(negedge clk) begin
        if (rsp0_valid && rsp1_valid) begin
            checks++; errors++;
            $display("FAIL rsp_both: both response valids high (cycle %0d)", cyc);
        end else if (rsp0_valid || rsp1_valid) begin
            int p;
            exp_t e;
            p = rsp1_valid ? 1 : 0;
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected: port %0d response with none outstanding (cycle %0d)", p, cyc);
            end else begin
                e = q.pop_front();
                chk("rsp_port", DW'(p), DW'(e.port));
                chk("rsp_latency", DW'(cyc), DW'(e.cyc + 2));
                chk("rsp_rdata1", p ? rsp1_rdata1 : rsp0_rdata1, e.d1);
                chk("rsp_rdata2", p ? rsp1_rdata2 : rsp0_rdata2, e.d2);
            end
        end
    end

    task automatic set_req(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        v[p] = 1'b1; we[p] = w; wa[p] = a; wd[p] = d; r1[p] = a1; r2[p] = a2;
    endtask

    task automatic set_rand(input int p);
        set_req(p, 1'($urandom), AW'($urandom), {$urandom, $urandom}, AW'($urandom), AW'($urandom));
    endtask

    task automatic cycle();
        int acc;
        logic [1:0] rdy;
        bit ew, er;
        @(negedge clk);
        acc = -1;
        rdy = {req1_ready, req0_ready};
        if (init_done) begin
            if (v[0] && v[1]) begin
                chk("arb_ready0", DW'(rdy[0]), DW'(rr_m == 0));
                chk("arb_ready1", DW'(rdy[1]), DW'(rr_m == 1));
            end
            for (int p = 0; p < 2; p++) if (v[p] && rdy[p]) acc = p;
            ew = prev_acc && prev_we && !(R0 && prev_wa == '0);
            er = prev_acc && !prev_we;
            chk("issue_wr", DW'(rf_WR), DW'(ew));
            chk("issue_rd", DW'(rf_RD), DW'(er));
            if (ew) begin
                chk("issue_si1", DW'(rf_si1), DW'(prev_wa));
                chk("issue_i1", rf_I1, prev_wd);
            end
            if (er) begin
                chk("issue_so1", DW'(rf_so1), DW'(prev_r1));
                chk("issue_so2", DW'(rf_so2), DW'(prev_r2));
                chk("issue_en", DW'(rf_EN), 1);
            end
        end
        prev_acc = (acc >= 0);
        if (acc >= 0) begin
            last_grant = acc;
            rr_m = 1 - acc;
            prev_we = we[acc]; prev_wa = wa[acc]; prev_wd = wd[acc];
            prev_r1 = r1[acc]; prev_r2 = r2[acc];
            if (we[acc]) begin
                if (!(R0 && wa[acc] == '0)) mmem[wa[acc]] = wd[acc];
            end else begin
                q.push_back('{acc, model_rd(r1[acc]), model_rd(r2[acc]), cyc});
            end
        end
        @(posedge clk);
        #1;
        if (acc >= 0) v[acc] = 1'b0;
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while (v != 0 && n < budget) begin
            cycle();
            n++;
        end
        if (v != 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout: requests still pending after %0d cycles", budget);
            v = '0;
        end
    endtask

    task automatic drain();
        repeat (4) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v = '0;
        q.delete();
        for (int i = 0; i < NREG; i++) mmem[i] = '0;
        rr_m = 0;
        prev_acc = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            chk("init_wr", DW'(rf_WR), 1);
            chk("init_i1", rf_I1, '0);
            chk("init_si1", DW'(rf_si1), DW'(i));
            chk("init_done_low", DW'(init_done), 0);
            if (i == 0) begin
                chk("init_en", DW'(rf_EN), 1);
                chk("init_rd", DW'(rf_RD), 0);
                chk("init_ready", DW'({req1_ready, req0_ready}), 0);
                chk("init_rsp", DW'({rsp1_valid, rsp0_valid}), 0);
            end
        end
        @(posedge clk);
        #1;
        chk("init_done_high", DW'(init_done), 1);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            wa[p] = '0; r1[p] = '0; r2[p] = '0; wd[p] = '0;
        end
        do_reset();

        // Back-to-back contention straight after init: grants must alternate from port 0.
        for (int k = 0; k < 4; k++) begin
            if (!v[0]) set_req(0, 1'b0, '0, '0, AW'($urandom), AW'($urandom));
            if (!v[1]) set_req(1, 1'b0, '0, '0, AW'($urandom), AW'($urandom));
            cycle();
            chk("grant_seq", DW'(last_grant), DW'(k % 2));
        end
        run_idle(10);
        drain();

        set_req(0, 1'b1, 4'd3, 64'h000F_0000_000F_0000, '0, '0);
        run_idle(10);
        set_req(0, 1'b0, '0, '0, 4'd3, 4'd1);
        run_idle(10);
        drain();

        // Write then read of the same register on consecutive accepts.
        set_req(1, 1'b1, 4'd5, 64'hF000_0000_000F_0000, '0, '0);
        run_idle(10);
        set_req(1, 1'b0, '0, '0, 4'd5, 4'd3);
        run_idle(10);
        drain();

        set_req(0, 1'b1, 4'd0, '1, '0, '0);
        run_idle(10);
        set_req(0, 1'b0, '0, '0, 4'd0, 4'd5);
        run_idle(10);
        drain();

        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) if (!v[p] && ($urandom % 2) == 0) set_rand(p);
            cycle();
        end
        run_idle(20);
        drain();

        // Reset lands in the issue cycle of a read: its response must vanish.
        set_req(0, 1'b0, '0, '0, 4'd3, 4'd5);
        run_idle(10);
        do_reset();
        set_req(1, 1'b0, '0, '0, 4'd3, 4'd5);
        run_idle(10);
        drain();

        chk("queue_empty", DW'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
